// File: rtl/golomb_pkg.sv
// golomb_pkg
// Shared types and constants for the mark_counter family.
//   head_state_t : FSM states of the head mark (IDLE, RUN, DONE)
//   MARK_WIDTH   : default mark position width
//   mark_t       : mark position type at the default width
package golomb_pkg;

    localparam int unsigned MARK_WIDTH = 9;

    typedef logic [MARK_WIDTH-1:0] mark_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } head_state_t;

endpackage : golomb_pkg

// File: rtl/mark_counter_head_ranged_if.sv
// mark_counter_head_ranged_if
// Host/downstream bundle of the ranged head mark.
//   master modport (host / downstream side):
//     drives load, range_lo, range_hi, next_req
//   slave modport (mark_counter_head_ranged):
//     drives ready, val, nextStartValue, issue, done, load_err
//     and issued_count when MARK_COUNTER_HEAD_STATS_EN is defined
// Optional feature macro: MARK_COUNTER_HEAD_STATS_EN
interface mark_counter_head_ranged_if
    import golomb_pkg::*;
#(
    parameter int unsigned WIDTH = MARK_WIDTH
) ();

    logic             load;
    logic [WIDTH-1:0] range_lo;
    logic [WIDTH-1:0] range_hi;
    logic             next_req;
    logic             ready;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] nextStartValue;
    logic             issue;
    logic             done;
    logic             load_err;
`ifdef MARK_COUNTER_HEAD_STATS_EN
    logic [WIDTH:0]   issued_count;
`endif

    modport master (
        output load, range_lo, range_hi, next_req,
        input  ready, val, nextStartValue, issue, done, load_err
`ifdef MARK_COUNTER_HEAD_STATS_EN
        , input issued_count
`endif
    );

    modport slave (
        input  load, range_lo, range_hi, next_req,
        output ready, val, nextStartValue, issue, done, load_err
`ifdef MARK_COUNTER_HEAD_STATS_EN
        , output issued_count
`endif
    );

endinterface : mark_counter_head_ranged_if

// File: rtl/mark_counter_head_ranged.sv
// mark_counter_head_ranged
// Head of the mark_counter chain. Owns position 0 and walks a host-loaded
// range [range_lo, range_hi] of first-distance values, handing them one at a
// time to the first downstream mark.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high reset
//   bus   : mark_counter_head_ranged_if.slave
//           in  load, range_lo, range_hi, next_req
//           out ready, val, nextStartValue, issue, done, load_err
//           out issued_count (only with MARK_COUNTER_HEAD_STATS_EN)
// Optional feature macro: MARK_COUNTER_HEAD_STATS_EN adds a saturating count
// of issue pulses since the last accepted load.
module mark_counter_head_ranged
    import golomb_pkg::*;
#(
    parameter int unsigned WIDTH       = MARK_WIDTH,
    parameter int unsigned RESET_START = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    mark_counter_head_ranged_if.slave   bus
);

    head_state_t      r_state;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_hi;
    logic             r_ready;
    logic             r_issue;
    logic             r_done;
    logic             r_load_err;
    logic             w_load_ok;

    // An empty range (lo > hi) or a zero first distance can never be issued.
    assign w_load_ok = (bus.range_lo != '0) && (bus.range_lo <= bus.range_hi);

`ifdef MARK_COUNTER_HEAD_STATS_EN
    logic [WIDTH:0] r_cnt;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cur      <= WIDTH'(RESET_START);
            r_hi       <= '0;
            r_ready    <= 1'b0;
            r_issue    <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
`ifdef MARK_COUNTER_HEAD_STATS_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_issue    <= 1'b0;
            r_load_err <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    // DONE differs from IDLE only in holding done and the
                    // last issued value; a rejected load leaves both intact.
                    if (bus.load) begin
                        if (w_load_ok) begin
                            r_state <= RUN;
                            r_cur   <= bus.range_lo;
                            r_hi    <= bus.range_hi;
                            r_ready <= 1'b1;
                            r_done  <= 1'b0;
                            r_issue <= 1'b1;
`ifdef MARK_COUNTER_HEAD_STATS_EN
                            r_cnt   <= (WIDTH+1)'(1);
`endif
                        end else begin
                            r_load_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.next_req) begin
                        // Compare before incrementing so cur never passes hi
                        // and cannot wrap at the top of the range.
                        if (r_cur < r_hi) begin
                            r_cur   <= r_cur + 1'b1;
                            r_issue <= 1'b1;
`ifdef MARK_COUNTER_HEAD_STATS_EN
                            if (r_cnt != '1) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
`endif
                        end else begin
                            r_state <= DONE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.val            = '0;
    assign bus.ready          = r_ready;
    assign bus.nextStartValue = r_cur;
    assign bus.issue          = r_issue;
    assign bus.done           = r_done;
    assign bus.load_err       = r_load_err;
`ifdef MARK_COUNTER_HEAD_STATS_EN
    assign bus.issued_count   = r_cnt;
`endif

endmodule : mark_counter_head_ranged

// File: doc/mark_counter_head_ranged.md
# mark_counter_head_ranged

- Parametrised successor to the fixed head mark. The mark value stays at position 0.
- Instead of a constant start value of 1, the block walks an externally loaded range of first-distance values [range_lo, range_hi] and hands them one at a time to the first downstream mark.
- This lets a host split the search space into work units, one range per ruler engine. The block sits at the head of the mark_counter chain.

## Interface
Parameters:
- WIDTH, 9: width of every mark position.
- RESET_START, 1: value driven on nextStartValue while not running.

Ports:
- Clock and reset: single clock; reset is asynchronous and active-high.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  single-cycle request to start a new range
- range_lo  in  WIDTH  first start value to issue
- range_hi  in  WIDTH  last start value to issue (inclusive)
- next_req  in  1  downstream has exhausted the current start value and requests the next one
- ready  out  1  nextStartValue is valid and stable (RUN state only)
- val  out  WIDTH  owned position, constant 0
- nextStartValue  out  WIDTH  start value for the first downstream mark
- issue  out  1  one-cycle pulse each time a new nextStartValue becomes valid
- done  out  1  range exhausted; held until the next accepted load
- load_err  out  1  one-cycle pulse when a load is rejected

## Operation
States: IDLE, RUN, DONE.

IDLE (reset state):
- ready=0, done=0, nextStartValue=RESET_START.
- A load is accepted when range_lo≥1 and range_lo≤range_hi:
  - capture range_hi and set cur=range_lo;
  - go to RUN and pulse issue.
- Otherwise, a load with range_lo==0 or range_lo>range_hi is rejected: pulse load_err and stay in IDLE.

RUN:
- ready=1 and nextStartValue=cur.
- On next_req with cur<hi: cur←cur+1 and pulse issue.
- On next_req with cur==hi: go to DONE.
- load is ignored in RUN with no error. There is no mid-range abort; only reset aborts.

DONE:
- done=1, ready=0, nextStartValue holds the last issued value.
- A load is handled exactly as in IDLE, except that a rejected load stays in DONE.

General rules:
- val=0 in every state and during reset.
- Arithmetic is unsigned WIDTH bits. cur never increments past hi, so no wrap-around can occur even when range_hi=2^WIDTH−1.
- next_req outside RUN is ignored.
- A load in the same cycle as next_req is only meaningful in IDLE/DONE, where next_req is ignored, so the two never conflict.
- Reset mid-RUN: state forced to IDLE immediately (asynchronous); every output takes its reset value.

## Timing
- Reset values: ready=0, val=0, nextStartValue=RESET_START, issue=0, done=0, load_err=0.
- All outputs are registered.
- Load latency: load sampled at edge N, then ready=1, issue=1 and nextStartValue=range_lo are visible after edge N.
- Step latency: next_req sampled at edge N, then the new nextStartValue and issue pulse appear after edge N.
- Throughput: one value per cycle if next_req is held high. Each next_req cycle consumes exactly one value.
- Exhaustion: on the next_req for hi, done=1 after that edge and ready=0 in the same cycle. issue is not pulsed.
- load_err: asserted for exactly one cycle, the cycle following the rejected load edge.

## Configuration
- MARK_COUNTER_HEAD_STATS_EN defined:
  - adds output issued_count [WIDTH:0], which counts issue pulses since the last accepted load;
  - cleared by reset and by every accepted load;
  - saturates at all-ones.
- MARK_COUNTER_HEAD_STATS_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package golomb_pkg:
  - state enum head_state_t {IDLE, RUN, DONE};
  - the default mark width constant MARK_WIDTH=9;
  - the mark_t typedef used across the mark_counter family.
- No sub-module. The block is a single FSM plus the cur/hi registers and the optional stats counter.

## Test plan
- Reset released, no load: ready=0, val=0, nextStartValue=1, done=0 held for 10 cycles.
- load lo=3, hi=5, then next_req pulsed 3 times:
  - issue pulses with nextStartValue 3, 4, 5;
  - done=1 after the third next_req;
  - issued_count=3 if the stats macro is enabled.
- load lo=0, hi=4, then lo=7, hi=2: load_err pulses once per load; state stays IDLE.
- WIDTH=9, load lo=510, hi=511, next_req held high: values 510, 511, then done; no wrap to 0.
- Mid-RUN (cur=4): load with lo=1 is ignored; then reset asserted asynchronously between edges: all outputs at reset values immediately, and a subsequent load lo=2, hi=2 gives a single issue of 2.
- From DONE, load lo=6, hi=6: done=0 and ready=1 with nextStartValue=6 one edge later.
